// File: rtl/xalu_pkg.sv
// Shared constants for the nibble-serial ALU: op codes, FSM states, slice width.
package xalu_pkg;

  localparam int NIB_W = 4;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_SHL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xalu_word_seq_if.sv
// Start/busy/done operation bus of the word sequencer.
// XALU_WORD_SEQ_ROT_EN adds the rot request bit.
interface xalu_word_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic             com;
  logic             cin;
`ifdef XALU_WORD_SEQ_ROT_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg_zero;
  logic             equ;

  modport master (
    output start, op, com, cin, a, b,
`ifdef XALU_WORD_SEQ_ROT_EN
    output rot,
`endif
    input  busy, done, result, cout, zero, neg_zero, equ
  );

  modport slave (
    input  start, op, com, cin, a, b,
`ifdef XALU_WORD_SEQ_ROT_EN
    input  rot,
`endif
    output busy, done, result, cout, zero, neg_zero, equ
  );
endinterface

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice; carries/shift bits enter and leave on both sides
// so a sequencer can chain nibbles in either direction.
module alu4_slice
  import xalu_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             ci_right_i,
  input  logic             ci_left_i,
  input  logic [2:0]       op_i,
  input  logic             com_i,
  output logic [NIB_W-1:0] r_o,
  output logic             co_left_o,
  output logic             co_right_o,
  output logic             eq_o
);
  logic [NIB_W:0]   sum;
  logic [NIB_W-1:0] raw;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    sum        = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, ci_right_i};
    raw        = '0;
    co_left_o  = 1'b0;
    co_right_o = 1'b0;
    case (op_i)
      OP_ADD:   begin raw = sum[NIB_W-1:0]; co_left_o = sum[NIB_W]; end
      OP_AND:   raw = a_i & b_i;
      OP_OR:    raw = a_i | b_i;
      OP_XOR:   raw = a_i ^ b_i;
      OP_PASSA: raw = a_i;
      OP_PASSB: raw = b_i;
      OP_SHR:   begin raw = {ci_left_i, a_i[NIB_W-1:1]}; co_right_o = a_i[0]; end
      OP_SHL:   begin raw = {a_i[NIB_W-2:0], ci_right_i}; co_left_o = a_i[NIB_W-1]; end
      default:  raw = '0;
    endcase
    r_o = com_i ? ~raw : raw;
  end

  assign eq_o = (a_i == b_i);
endmodule

// File: rtl/xalu_word_seq.sv
// Runs alu4_slice over a WIDTH-bit word one nibble per clock, chaining the link bit.
// Define XALU_WORD_SEQ_ROT_EN to add the rot input (shifts become rotates).
module xalu_word_seq
  import xalu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  xalu_word_seq_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             link_q, link_d;
  logic             busy_q, done_q, cout_q, zero_q, neg_zero_q, equ_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
  logic [2:0]       op_q;
  logic             com_q, eq_acc_q, eq_d;
  logic             load, seed;
  logic [IDX_W-1:0] nib_sel;
  logic [IDX_W+1:0] base;
  logic [NIB_W-1:0] slice_r;
  logic             slice_co_left, slice_co_right, slice_eq;

  assign load = bus.start && (state_q != ST_RUN);

  // Link seed: cin, or the bit leaving the word when rotating.
  always_comb begin
    seed = bus.cin;
`ifdef XALU_WORD_SEQ_ROT_EN
    if (bus.rot && bus.op == OP_SHL) seed = bus.a[WIDTH-1];
    if (bus.rot && bus.op == OP_SHR) seed = bus.a[0];
`endif
  end

  always_comb begin
    nib_sel = (op_q == OP_SHR) ? (LAST - idx_q) : idx_q;
    base    = {nib_sel, 2'b00};
  end

  alu4_slice u_slice (
    .a_i        (a_q[base +: NIB_W]),
    .b_i        (b_q[base +: NIB_W]),
    .ci_right_i (link_q),
    .ci_left_i  (link_q),
    .op_i       (op_q),
    .com_i      (com_q),
    .r_o        (slice_r),
    .co_left_o  (slice_co_left),
    .co_right_o (slice_co_right),
    .eq_o       (slice_eq)
  );

  always_comb begin
    work_d              = work_q;
    work_d[base +: NIB_W] = slice_r;
    eq_d                = eq_acc_q & slice_eq;
    link_d              = link_q;
    case (op_q)
      OP_ADD, OP_SHL: link_d = slice_co_left;
      OP_SHR:         link_d = slice_co_right;
      default:        link_d = link_q;
    endcase
  end

  // NOTE: operand and work registers carry no reset; they are always loaded
  // before use, and only the FSM and the visible outputs need a defined value.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      op_q     <= bus.op;
      com_q    <= bus.com;
      eq_acc_q <= 1'b1;
    end else if (state_q == ST_RUN) begin
      work_q   <= work_d;
      eq_acc_q <= eq_d;
    end
  end

  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      link_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_zero_q <= 1'b0;
      equ_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            link_q  <= seed;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          link_q <= link_d;
          if (idx_q == LAST) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= work_d;
            cout_q     <= (op_q == OP_ADD || op_q == OP_SHL || op_q == OP_SHR) ? link_d : 1'b0;
            zero_q     <= (work_d == '0);
            neg_zero_q <= (&work_d);
            equ_q      <= eq_d;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.neg_zero = neg_zero_q;
  assign bus.equ      = equ_q;
endmodule

// File: tb/tb_xalu_word_seq.sv
// Bench for xalu_word_seq (WIDTH=16): vector table, random ops against a word-level
// model, and hand-written handshake/reset sequences. Honours XALU_WORD_SEQ_ROT_EN.
module tb_xalu_word_seq;
  import xalu_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;

  xalu_word_seq_if #(.WIDTH(WIDTH)) bus ();

  xalu_word_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // flags = {cout, zero, neg_zero, equ}
  typedef struct {
    logic [2:0]  op;
    logic        com;
    logic        cin;
    logic        rot;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic com, input logic cin,
                              input logic rot, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] res, input logic [3:0] flags);
    vec_t v;
    v.op = op; v.com = com; v.cin = cin; v.rot = rot;
    v.a = a; v.b = b; v.res = res; v.flags = flags;
    return v;
  endfunction

  // Word-level reference: whole-word arithmetic, no nibble stepping.
  function automatic vec_t model(input vec_t v);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        seed;
    seed = v.cin;
    if (v.rot && v.op == OP_SHL) seed = v.a[15];
    if (v.rot && v.op == OP_SHR) seed = v.a[0];
    c = 1'b0;
    r = '0;
    case (v.op)
      OP_ADD:   begin s = {1'b0, v.a} + {1'b0, v.b} + 17'(v.cin); r = s[15:0]; c = s[16]; end
      OP_AND:   r = v.a & v.b;
      OP_OR:    r = v.a | v.b;
      OP_XOR:   r = v.a ^ v.b;
      OP_PASSA: r = v.a;
      OP_PASSB: r = v.b;
      OP_SHR:   begin r = {seed, v.a[15:1]}; c = v.a[0]; end
      default:  begin r = {v.a[14:0], seed}; c = v.a[15]; end
    endcase
    if (v.com) r = ~r;
    v.res   = r;
    v.flags = {c, (r == 16'h0000), (r == 16'hFFFF), (v.a == v.b)};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.op  = v.op;
    bus.com = v.com;
    bus.cin = v.cin;
    bus.a   = v.a;
    bus.b   = v.b;
`ifdef XALU_WORD_SEQ_ROT_EN
    bus.rot = v.rot;
`endif
  endtask

  function automatic logic [3:0] out_flags();
    return {bus.cout, bus.zero, bus.neg_zero, bus.equ};
  endfunction

  task automatic run_op(input vec_t v, output logic [15:0] res, output logic [3:0] flags,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
    res   = bus.result;
    flags = out_flags();
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    logic [15:0] res;
    logic [3:0]  flags;
    int          lat;
    bit          busy_ok;
    run_op(v, res, flags, lat, busy_ok);
    check({tag, "_result"}, 32'(res), 32'(v.res));
    check({tag, "_flags"}, 32'(flags), 32'(v.flags));
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    vec_t        v;
    int          done_at, done_at2, ndone;
    logic [15:0] res1, res2;

    rst       = 1'b1;
    bus.start = 1'b0;
    drive(mk(OP_ADD, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'h0));
    repeat (3) @(negedge clk);
    check("reset_ctrl_flags", 32'({bus.busy, bus.done, out_flags()}), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    rst = 1'b0;

    vecs.push_back(mk(OP_ADD,   1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000));
    vecs.push_back(mk(OP_ADD,   1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100));
    vecs.push_back(mk(OP_SHR,   1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000, 16'hC000, 4'b1000));
    vecs.push_back(mk(OP_SHL,   1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h0002, 4'b1000));
    vecs.push_back(mk(OP_XOR,   1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'hFFFF, 4'b0011));
    vecs.push_back(mk(OP_AND,   1'b0, 1'b1, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000));
    vecs.push_back(mk(OP_OR,    1'b0, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 4'b0000));
    vecs.push_back(mk(OP_PASSA, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hFF00, 4'b0000));
    vecs.push_back(mk(OP_PASSB, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hABCD, 16'hABCD, 4'b0000));
    vecs.push_back(mk(OP_ADD,   1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h8000, 4'b0000));
    vecs.push_back(mk(OP_ADD,   1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'hFFFD, 4'b0001));
    vecs.push_back(mk(OP_SHL,   1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h8001, 4'b0000));
    vecs.push_back(mk(OP_AND,   1'b0, 1'b0, 1'b0, 16'h5555, 16'h5555, 16'h5555, 4'b0001));
    vecs.push_back(mk(OP_ADD,   1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1101));
    vecs.push_back(mk(OP_XOR,   1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b0010));
    vecs.push_back(mk(OP_SHR,   1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0001, 4'b0000));
`ifdef XALU_WORD_SEQ_ROT_EN
    vecs.push_back(mk(OP_SHL,   1'b0, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h0003, 4'b1000));
    vecs.push_back(mk(OP_SHR,   1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'h8000, 4'b1000));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      v.op  = 3'($urandom_range(0, 7));
      v.com = 1'($urandom);
      v.cin = 1'($urandom);
`ifdef XALU_WORD_SEQ_ROT_EN
      v.rot = 1'($urandom);
`else
      v.rot = 1'b0;
`endif
      v.a = 16'($urandom);
      v.b = ($urandom_range(0, 3) == 0) ? v.a : 16'($urandom);
      v = model(v);
      run_and_check($sformatf("rnd%0d_op%0d", i, v.op), v);
    end

    // start pulses during RUN must be ignored, inputs not re-sampled
    @(negedge clk);
    drive(mk(OP_ADD, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0, 4'h0));
    bus.start = 1'b1;
    done_at = 0; ndone = 0; res1 = '0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 2 || cyc == 3);
      if (cyc == 2) drive(mk(OP_OR, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 4'h0));
      if (bus.done) begin
        ndone++;
        if (done_at == 0) begin done_at = cyc; res1 = bus.result; end
      end
    end
    bus.start = 1'b0;
    check("ign_done_cycle", 32'(done_at), 32'd5);
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_result", 32'(res1), 32'h0002);
    check("ign_result_held", 32'(bus.result), 32'h0002);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    drive(mk(OP_XOR, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0F0F, 16'h0, 4'h0));
    bus.start = 1'b1;
    done_at = 0; done_at2 = 0; res1 = '0; res2 = '0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 5);
      if (cyc == 5) drive(mk(OP_ADD, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h0, 4'h0));
      if (bus.done) begin
        if (done_at == 0) begin done_at = cyc; res1 = bus.result; end
        else if (done_at2 == 0) begin done_at2 = cyc; res2 = bus.result; end
      end
    end
    bus.start = 1'b0;
    check("b2b_first_done", 32'(done_at), 32'd5);
    check("b2b_first_result", 32'(res1), 32'h0FF0);
    check("b2b_second_done", 32'(done_at2), 32'd10);
    check("b2b_second_result", 32'(res2), 32'h2000);
    check("b2b_second_flags", 32'(out_flags()), 32'b0001);

    // reset asserted in cycle 3 aborts the op
    @(negedge clk);
    drive(mk(OP_PASSA, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 4'h0));
    bus.start = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) ndone++;
      if (cyc == 3) rst = 1'b1;
      if (cyc == 4) begin
        rst = 1'b0;
        check("rstrun_ctrl_flags", 32'({bus.busy, bus.done, out_flags()}), 32'd0);
        check("rstrun_result", 32'(bus.result), 32'd0);
      end
    end
    check("rstrun_no_done", 32'(ndone), 32'd0);

    run_and_check("post_reset", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/xalu_word_seq.md
Name: xalu_word_seq

Overview:
Multi-cycle sequencer that runs a single 4-bit ALU slice over a WIDTH-bit word, one nibble per clock, chaining carries and shift bits between nibbles through registered state.
- Accepts a word-level operation with a start/busy/done handshake.
- Returns word result, carry-out and word-level status flags.
- Sits between the instruction/control logic and the nibble ALU datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIBBLES, WIDTH/4, derived local constant; number of RUN cycles per operation

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE or DONE
op  input  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
com  input  1  ones'-complement output mode, applied to every nibble
cin  input  1  carry-in (ADD) or shift-in bit (SHL/SHR)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result and flags valid from this cycle
result  output  WIDTH  word result, held until the next done
cout  output  1  ADD: final carry; SHL: bit shifted out of a[WIDTH-1]; SHR: bit shifted out of a[0]; other ops 0
zero  output  1  result is all zeros
neg_zero  output  1  result is all ones
equ  output  1  a == b

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: state IDLE; busy, done, result, cout, zero, neg_zero, equ all 0; internal index and link bit cleared. Reset mid-RUN aborts the operation; no done is issued.
- States:
  - IDLE: start=1 latches a, b, op, com, cin; goes to RUN with idx=0.
  - RUN: processes one nibble per cycle; after nibble NIBBLES-1 goes to DONE.
  - DONE: done=1 for exactly this cycle. If start=1, latch and go straight to RUN (back-to-back); else go to IDLE.
- start is ignored while in RUN. Inputs are never re-sampled mid-operation.
- Latency: start sampled at edge k; done high in cycle k+NIBBLES+1 (cycle 5 for WIDTH=16). Throughput is one operation per NIBBLES+1 cycles.
- Nibble order: LSB-first (nibble 0 up) for every op except SHR, which runs MSB-first.
- Link register:
  - ADD: link seeded with cin. Feeds ci_right; updated from the slice's left carry-out. cout = final link.
  - SHL: link seeded with cin. Feeds ci_right; updated from bit 3 of the current nibble of A. cout = a[WIDTH-1].
  - SHR: link seeded with cin. Feeds ci_left; updated from bit 0 of the current nibble of A. cout = a[0].
  - Logic and pass ops: link unused; cout = 0.
- com inverts every result nibble. com does not affect carry/cout.
- Result nibbles collect in a work register. result, cout, zero and neg_zero commit on the RUN→DONE edge, so outputs never show a partial word.
- equ is the AND of the per-nibble equality flags, committed at the same edge. It is independent of op and com.

Optional Feature:
XALU_WORD_SEQ_ROT_EN
- Defined: adds input port `rot` (1 bit), latched with start. When rot=1 and op is SHL or SHR, the link seed is the bit leaving the word (a[WIDTH-1] for SHL, a[0] for SHR) instead of cin, giving a rotate. cout is unchanged.
- Undefined: no `rot` port; shifts always take cin.

Decomposition:
- Shared package `xalu_pkg`: op-code localparams (OP_ADD … OP_SHL), state encoding (ST_IDLE, ST_RUN, ST_DONE), nibble width constant 4.
- One sub-module, `alu4_slice`: purely combinational 4-bit slice with the same function set.
  - Inputs: nibble A, nibble B, ci_right, ci_left, function code, com.
  - Outputs: nibble result, co_left, co_right, nibble equality.
- The sequencer instantiates it once and adds index counter, link register, operand/work registers and FSM.

Test Plan (WIDTH=16):
1. ADD a=0x00FF, b=0x0001, cin=0, start at cycle 0 → busy in cycles 1–4; done only in cycle 5; result=0x0100, cout=0, zero=0, equ=0.
2. ADD a=0xFFFF, b=0x0001, cin=0 → result=0x0000, cout=1, zero=1, neg_zero=0.
3. SHR a=0x8001, cin=1 → result=0xC000, cout=1. SHL a=0x8001, cin=0 → result=0x0002, cout=1.
4. XOR a=b=0x1234, com=1 → result=0xFFFF, neg_zero=1, zero=0, equ=1, cout=0.
5. Handshake and reset:
   - start pulses in cycles 2–3 while busy → ignored.
   - start held high in the DONE cycle → second done exactly 5 cycles later.
   - rst asserted in cycle 3 of an op → next cycle IDLE, all outputs 0, no done.
6. With XALU_WORD_SEQ_ROT_EN, rot=1: SHL a=0x8001, cin=0 → result=0x0003, cout=1. SHR a=0x0001 → result=0x8000, cout=1.
